// File: rtl/result_p2s_tx.sv
// result_p2s_tx: output stage after the ratio x sine datapath.
// Each result word is queued in a small FIFO and sent as a framed serial
// stream, one bit per clock: start (0), DATA_W data bits MSB first, an
// optional parity bit, then STOP_LEN stop bits (1). The upstream source
// cannot be stalled, so a word offered while the FIFO is full is dropped
// and the sticky overflow flag is set.
// Optional feature macro: PARITY_EN (adds an even-parity bit after the data).
module result_p2s_tx #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned STOP_LEN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic                   sout,
    output logic                   sout_frame,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   overflow
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned BCW = $clog2(DATA_W + 1);
    localparam int unsigned SCW = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;

    localparam logic [BCW-1:0] BitLast  = BCW'(DATA_W - 1);
    localparam logic [SCW-1:0] StopLast = SCW'(STOP_LEN - 1);
    localparam logic [AW:0]    CntFull  = (AW + 1)'(DEPTH);

`ifdef PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    // FIFO state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic [AW:0]       cnt_d;
    logic              ovf_q;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    // Transmitter state
    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [SCW-1:0]    stop_cnt_q;
    logic              sout_q;
    logic              frame_q;
`ifdef PARITY_EN
    logic              par_q;
`endif

    // Ready depends only on the current count, so a full FIFO never accepts
    // even in a cycle where the transmitter pops.
    assign din_ready = (cnt_q != CntFull);
    assign push      = din_valid && din_ready;
    assign head      = mem_q[rd_ptr_q];

    // Pop when idle, or on the last stop cycle so frames run back-to-back.
    assign pop = (cnt_q != '0) &&
                 ((state_q == StIdle) || ((state_q == StStop) && (stop_cnt_q == '0)));

    assign sout       = sout_q;
    assign sout_frame = frame_q;
    assign busy       = (state_q != StIdle) || (cnt_q != '0);
    assign fifo_cnt   = cnt_q;
    assign overflow   = ovf_q;

    // Occupancy update: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointers, count and sticky overflow; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
            if (din_valid && !din_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Frame sequencer; sout/sout_frame are registered from the current state,
    // so the line lags the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            sout_q     <= 1'b1;
            frame_q    <= 1'b0;
`ifdef PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    sout_q  <= 1'b1;
                    frame_q <= 1'b0;
                    if (pop) begin
                        shift_q <= head;
`ifdef PARITY_EN
                        par_q   <= ^head;
`endif
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    sout_q    <= 1'b0;
                    frame_q   <= 1'b1;
                    bit_cnt_q <= BitLast;
                    state_q   <= StData;
                end
                StData: begin
                    sout_q  <= shift_q[DATA_W-1];
                    frame_q <= 1'b1;
                    shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                    if (bit_cnt_q == '0) begin
`ifdef PARITY_EN
                        state_q    <= StParity;
`else
                        stop_cnt_q <= StopLast;
                        state_q    <= StStop;
`endif
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
`ifdef PARITY_EN
                StParity: begin
                    sout_q     <= par_q;
                    frame_q    <= 1'b1;
                    stop_cnt_q <= StopLast;
                    state_q    <= StStop;
                end
`endif
                StStop: begin
                    sout_q  <= 1'b1;
                    frame_q <= 1'b1;
                    if (stop_cnt_q == '0) begin
                        if (pop) begin
                            shift_q <= head;
`ifdef PARITY_EN
                            par_q   <= ^head;
`endif
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        stop_cnt_q <= stop_cnt_q - 1'b1;
                    end
                end
                default: begin
                    sout_q  <= 1'b1;
                    frame_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
